svc_axi_sram_if: RTL and testbench
==================================

# svc_axi_sram_if

AXI4 subordinate that converts AXI read and write bursts into the single-beat `sram_cmd_*` / `sram_resp_rd_*` stream consumed by the SRAM I/O controller (`svc_ice40_sram_io_if`). It is the initiator end of that command/response interface. One burst is in flight at a time, and a fair arbiter alternates between reads and writes.

## Interface
- `AXI_ADDR_WIDTH`, 20, byte address width
- `AXI_DATA_WIDTH`, 16, data width; equals SRAM data width
- `AXI_ID_WIDTH`, 4, transaction ID width
- `LSB`, $clog2(AXI_DATA_WIDTH/8), byte-to-word shift (derived)
- `SRAM_ADDR_WIDTH`, AXI_ADDR_WIDTH-LSB, word address width (derived)
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1 — clock
- `rst` in 1 — synchronous active-high reset
- `s_axi_aw{valid,ready,id,addr,len,size,burst}` — AW channel (valid in, ready out; len 8b)
- `s_axi_w{valid,ready,data,strb,last}` — W channel
- `s_axi_b{valid,ready,id,resp}` — B channel (valid out, ready in)
- `s_axi_ar{valid,ready,id,addr,len,size,burst}` — AR channel
- `s_axi_r{valid,ready,id,data,resp,last}` — R channel
- `sram_cmd_valid` out 1; `sram_cmd_ready` in 1; `sram_cmd_addr` out SRAM_ADDR_WIDTH; `sram_cmd_wr_en` out 1; `sram_cmd_wr_data` out AXI_DATA_WIDTH; `sram_cmd_wr_strb` out AXI_DATA_WIDTH/8
- `sram_resp_rd_valid` in 1; `sram_resp_rd_ready` out 1; `sram_resp_rd_data` in AXI_DATA_WIDTH

## Operation
- States: IDLE, READ, WRITE, WRITE_RESP.
- IDLE:
  - `arready` = grant_rd; `awready` = grant_wr.
  - When only one of AR/AW is valid, that channel is granted.
  - When both are valid, the channel not served last is granted. `last_was_write` resets to 1, so the first contest goes to read.
- AR handshake: latch id, addr>>LSB, len. Set `cmd_cnt`=0 and `resp_cnt`=0. Go to READ.
- READ:
  - `sram_cmd_valid` = (cmd_cnt ≤ len); `wr_en`=0.
  - On each cmd handshake, addr+1 and cmd_cnt+1.
  - R channel is a pass-through: `rvalid` = `sram_resp_rd_valid`, `sram_resp_rd_ready` = `rready`, `rdata` = `sram_resp_rd_data`.
  - `rid` = latched id; `rlast` = (resp_cnt == len); `rresp` = OKAY (2'b00).
  - R handshake with `rlast` set: go to IDLE and set `last_was_write`=0.
- AW handshake: latch id, addr>>LSB, len. Set `cmd_cnt`=0. Go to WRITE.
- WRITE:
  - `sram_cmd_valid` = `wvalid`; `wready` = `sram_cmd_ready`; `wr_en`=1.
  - `wr_data`/`wr_strb` pass through from W.
  - On a handshake with cmd_cnt == len, go to WRITE_RESP. Otherwise addr+1 and cmd_cnt+1.
- WRITE_RESP: `bvalid`=1, `bid` = latched id, `bresp` = OKAY. On `bready`, go to IDLE and set `last_was_write`=1.
- Burst type and size:
  - `*burst` and `*size` are ignored (SVC_UNUSED); all bursts are INCR at full width.
  - `wlast` is ignored; the internal beat count ends the burst.
- Word address wraps modulo 2^SRAM_ADDR_WIDTH (all-ones + 1 → 0).
- Counters are 9 bits, so len=255 yields 256 beats.

## Timing
- Reset: state=IDLE, `last_was_write`=1. All outputs are 0: `awready`, `arready`, `wready`, `bvalid`, `rvalid`, `sram_cmd_valid`, `sram_resp_rd_ready`.
- The AR/AW handshake in cycle N puts the first `sram_cmd_valid` in cycle N+1. No command is issued in the handshake cycle.
- Commands issue back-to-back at one per cycle while `sram_cmd_ready`=1.
- R data latency equals the downstream latency. No added register stage.
- Cmd outputs are stable while valid && !ready: W and addr hold, and the internal addr/cnt only advance on handshake.
- `bvalid` rises the cycle after the last W handshake.
- IDLE is re-entered for one cycle between bursts. Minimum burst-to-burst gap is 1 cycle.
- `rst` mid-burst:
  - Drops to IDLE next cycle; all responses are abandoned.
  - The downstream controller must be reset in the same cycle.

## Structure
- No shared package. `state_t` and the OKAY constant are module-local localparams.
- No sub-module is needed. Counters, address register and arbiter flag are inline.

## Test plan
- Reset, then single write: AW addr 0x0010, len=0; W data 0xBEEF strb 2'b11 → one sram cmd with addr 0x0008, wr_en=1, data 0xBEEF; B id matches, resp 0.
- Read burst: AR addr 0x0000, len=3; responder returns 0x1111..0x4444 → cmds at addr 0..3; R beats in order with rlast only on beat 4; rid matches.
- Backpressure: `sram_cmd_ready` toggles 1/0 and `rready` is low for 3 cycles mid-burst → no cmd or beat is lost or duplicated; cmd signals stay stable while stalled.
- Arbitration: AW and AR valid in the same cycle out of reset → read is granted first. Repeat after both finish → write is granted.
- Wrap and long burst: AR at word addr all-ones, len=255 → second cmd addr 0; 256 R beats; rlast only on beat 256.
- Reset mid-read after 2 of 4 beats → next cycle all outputs are 0 and state=IDLE; a subsequent write completes normally.

Source files
------------

// File: rtl/svc_axi_sram_if.sv
// AXI4 subordinate that turns AXI read/write bursts into single-beat SRAM commands.
// One burst in flight at a time; reads and writes alternate when both are pending.
module svc_axi_sram_if #(
    parameter int AXI_ADDR_WIDTH  = 20,
    parameter int AXI_DATA_WIDTH  = 16,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int LSB             = $clog2(AXI_DATA_WIDTH / 8),
    parameter int SRAM_ADDR_WIDTH = AXI_ADDR_WIDTH - LSB
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,

    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,

    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,

    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,

    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,

    output logic                        sram_cmd_valid,
    input  logic                        sram_cmd_ready,
    output logic [SRAM_ADDR_WIDTH-1:0]  sram_cmd_addr,
    output logic                        sram_cmd_wr_en,
    output logic [AXI_DATA_WIDTH-1:0]   sram_cmd_wr_data,
    output logic [AXI_DATA_WIDTH/8-1:0] sram_cmd_wr_strb,

    input  logic                        sram_resp_rd_valid,
    output logic                        sram_resp_rd_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   sram_resp_rd_data
);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        WRITE_RESP
    } state_t;

    state_t                      state_q, state_d;
    logic                        last_wr_q, last_wr_d;
    logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
    logic [SRAM_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [7:0]                  len_q, len_d;
    logic [8:0]                  cmd_cnt_q, cmd_cnt_d;
    logic [8:0]                  resp_cnt_q, resp_cnt_d;
    logic                        grant_rd, grant_wr;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                         s_axi_wlast, s_axi_awaddr[LSB-1:0], s_axi_araddr[LSB-1:0]};

    // Contested grant goes to whichever direction was not served last.
    assign grant_rd = s_axi_arvalid && (!s_axi_awvalid || last_wr_q);
    assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || !last_wr_q);

    always_comb begin
        state_d            = state_q;
        last_wr_d          = last_wr_q;
        id_d               = id_q;
        addr_d             = addr_q;
        len_d              = len_q;
        cmd_cnt_d          = cmd_cnt_q;
        resp_cnt_d         = resp_cnt_q;
        s_axi_awready      = 1'b0;
        s_axi_arready      = 1'b0;
        s_axi_wready       = 1'b0;
        s_axi_bvalid       = 1'b0;
        s_axi_bid          = id_q;
        s_axi_bresp        = RESP_OKAY;
        s_axi_rvalid       = 1'b0;
        s_axi_rid          = id_q;
        s_axi_rdata        = sram_resp_rd_data;
        s_axi_rresp        = RESP_OKAY;
        s_axi_rlast        = 1'b0;
        sram_cmd_valid     = 1'b0;
        sram_cmd_addr      = addr_q;
        sram_cmd_wr_en     = 1'b0;
        sram_cmd_wr_data   = '0;
        sram_cmd_wr_strb   = '0;
        sram_resp_rd_ready = 1'b0;

        case (state_q)
            IDLE: begin
                s_axi_arready = grant_rd;
                s_axi_awready = grant_wr;
                if (grant_rd) begin
                    id_d       = s_axi_arid;
                    addr_d     = s_axi_araddr[AXI_ADDR_WIDTH-1:LSB];
                    len_d      = s_axi_arlen;
                    cmd_cnt_d  = '0;
                    resp_cnt_d = '0;
                    state_d    = READ;
                end else if (grant_wr) begin
                    id_d      = s_axi_awid;
                    addr_d    = s_axi_awaddr[AXI_ADDR_WIDTH-1:LSB];
                    len_d     = s_axi_awlen;
                    cmd_cnt_d = '0;
                    state_d   = WRITE;
                end
            end

            READ: begin
                sram_cmd_valid = (cmd_cnt_q <= {1'b0, len_q});
                if (sram_cmd_valid && sram_cmd_ready) begin
                    addr_d    = addr_q + SRAM_ADDR_WIDTH'(1);
                    cmd_cnt_d = cmd_cnt_q + 9'd1;
                end
                // Read data is forwarded combinationally; no buffering here.
                s_axi_rvalid       = sram_resp_rd_valid;
                sram_resp_rd_ready = s_axi_rready;
                s_axi_rlast        = (resp_cnt_q == {1'b0, len_q});
                if (s_axi_rvalid && s_axi_rready) begin
                    resp_cnt_d = resp_cnt_q + 9'd1;
                    if (s_axi_rlast) begin
                        state_d   = IDLE;
                        last_wr_d = 1'b0;
                    end
                end
            end

            WRITE: begin
                sram_cmd_valid   = s_axi_wvalid;
                s_axi_wready     = sram_cmd_ready;
                sram_cmd_wr_en   = 1'b1;
                sram_cmd_wr_data = s_axi_wdata;
                sram_cmd_wr_strb = s_axi_wstrb;
                if (s_axi_wvalid && sram_cmd_ready) begin
                    if (cmd_cnt_q == {1'b0, len_q}) begin
                        state_d = WRITE_RESP;
                    end else begin
                        addr_d    = addr_q + SRAM_ADDR_WIDTH'(1);
                        cmd_cnt_d = cmd_cnt_q + 9'd1;
                    end
                end
            end

            WRITE_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) begin
                    state_d   = IDLE;
                    last_wr_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
        end
    end

    // Burst bookkeeping is always loaded on the AR/AW handshake, so it needs no reset.
    always_ff @(posedge clk) begin
        id_q       <= id_d;
        addr_q     <= addr_d;
        len_q      <= len_d;
        cmd_cnt_q  <= cmd_cnt_d;
        resp_cnt_q <= resp_cnt_d;
    end

endmodule

// File: tb/tb_svc_axi_sram_if.sv
// Directed bench for svc_axi_sram_if with a queued SRAM read responder.
module tb_svc_axi_sram_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_axi_awvalid, s_axi_awready;
    logic [3:0]  s_axi_awid;
    logic [19:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_wvalid, s_axi_wready;
    logic [15:0] s_axi_wdata;
    logic [1:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [3:0]  s_axi_arid;
    logic [19:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_rvalid, s_axi_rready;
    logic [3:0]  s_axi_rid;
    logic [15:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        sram_cmd_valid, sram_cmd_ready;
    logic [18:0] sram_cmd_addr;
    logic        sram_cmd_wr_en;
    logic [15:0] sram_cmd_wr_data;
    logic [1:0]  sram_cmd_wr_strb;
    logic        sram_resp_rd_valid, sram_resp_rd_ready;
    logic [15:0] sram_resp_rd_data;

    svc_axi_sram_if dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awid(s_axi_awid),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_arid(s_axi_arid),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
        .sram_cmd_valid(sram_cmd_valid), .sram_cmd_ready(sram_cmd_ready),
        .sram_cmd_addr(sram_cmd_addr), .sram_cmd_wr_en(sram_cmd_wr_en),
        .sram_cmd_wr_data(sram_cmd_wr_data), .sram_cmd_wr_strb(sram_cmd_wr_strb),
        .sram_resp_rd_valid(sram_resp_rd_valid), .sram_resp_rd_ready(sram_resp_rd_ready),
        .sram_resp_rd_data(sram_resp_rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Responder data: nibble (addr[3:0]+1) replicated, so words 0..3 give 1111..4444.
    function automatic logic [15:0] rd_word(input logic [18:0] a);
        logic [3:0] n;
        n = a[3:0] + 4'd1;
        return {n, n, n, n};
    endfunction

    logic       tog_en = 1'b0;
    logic       tog_q  = 1'b0;
    always @(posedge clk) tog_q <= ~tog_q;
    assign sram_cmd_ready = tog_en ? tog_q : 1'b1;

    logic [15:0] rq[$];
    always @(posedge clk) begin
        if (rst) begin
            rq.delete();
            sram_resp_rd_valid <= 1'b0;
            sram_resp_rd_data  <= 16'h0;
        end else begin
            if (sram_resp_rd_valid && sram_resp_rd_ready) void'(rq.pop_front());
            if (sram_cmd_valid && sram_cmd_ready && !sram_cmd_wr_en) rq.push_back(rd_word(sram_cmd_addr));
            sram_resp_rd_valid <= (rq.size() != 0);
            sram_resp_rd_data  <= (rq.size() != 0) ? rq[0] : 16'h0;
        end
    end

    logic [18:0] cmd_addr_q[$];
    logic        cmd_we_q[$];
    logic [15:0] cmd_data_q[$];
    logic [1:0]  cmd_strb_q[$];
    logic [15:0] r_data_q[$];
    logic        r_last_q[$];
    logic [3:0]  r_id_q[$];
    logic [3:0]  b_id_q[$];
    logic [1:0]  b_resp_q[$];
    logic        stall_p = 1'b0;
    logic [37:0] stall_vec;

    always @(posedge clk) begin
        if (rst) begin
            stall_p <= 1'b0;
        end else begin
            if (stall_p)
                check("cmd_stable", {1'b1, sram_cmd_addr, sram_cmd_wr_en, sram_cmd_wr_data, sram_cmd_wr_strb},
                      {5'd0, 1'b1, stall_vec[36:0]});
            if (sram_cmd_valid && sram_cmd_ready) begin
                cmd_addr_q.push_back(sram_cmd_addr);
                cmd_we_q.push_back(sram_cmd_wr_en);
                cmd_data_q.push_back(sram_cmd_wr_data);
                cmd_strb_q.push_back(sram_cmd_wr_strb);
            end
            if (s_axi_rvalid && s_axi_rready) begin
                r_data_q.push_back(s_axi_rdata);
                r_last_q.push_back(s_axi_rlast);
                r_id_q.push_back(s_axi_rid);
            end
            if (s_axi_bvalid && s_axi_bready) begin
                b_id_q.push_back(s_axi_bid);
                b_resp_q.push_back(s_axi_bresp);
            end
            stall_p   <= sram_cmd_valid && !sram_cmd_ready;
            stall_vec <= {1'b0, sram_cmd_addr, sram_cmd_wr_en, sram_cmd_wr_data, sram_cmd_wr_strb};
        end
    end

    logic [6:0] outs_vec;
    assign outs_vec = {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                       s_axi_rvalid, sram_cmd_valid, sram_resp_rd_ready};

    task automatic aw_send(input logic [3:0] id, input logic [19:0] a, input logic [7:0] l, output bit ok);
        s_axi_awvalid = 1'b1; s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = l;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (s_axi_awready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        #1;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [19:0] a, input logic [7:0] l, output bit ok);
        s_axi_arvalid = 1'b1; s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = l;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (s_axi_arready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        #1;
    endtask

    task automatic w_send(input logic [15:0] d, input logic [1:0] s, output bit ok);
        s_axi_wvalid = 1'b1; s_axi_wdata = d; s_axi_wstrb = s; s_axi_wlast = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (s_axi_wready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        #1;
    endtask

    task automatic wait_r(input int target, input int budget);
        for (int i = 0; i < budget && r_data_q.size() < target; i++) @(negedge clk);
        #1;
    endtask

    task automatic wait_b(input int target);
        for (int i = 0; i < 50 && b_id_q.size() < target; i++) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int cb, rb, bb, nl;
        rst = 1'b1;
        s_axi_awvalid = 0; s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0;
        s_axi_awsize = 3'd1; s_axi_awburst = 2'b01;
        s_axi_wvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
        s_axi_bready = 0;
        s_axi_arvalid = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0;
        s_axi_arsize = 3'd1; s_axi_arburst = 2'b01;
        s_axi_rready = 0;
        repeat (3) @(negedge clk);
        #1 check("reset_outs", 32'(outs_vec), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        #1 check("idle_outs", 32'(outs_vec), 32'h0);

        // Single write
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        cb = cmd_addr_q.size(); bb = b_id_q.size();
        s_axi_awvalid = 1'b1; s_axi_awid = 4'h3; s_axi_awaddr = 20'h00010; s_axi_awlen = 8'd0;
        #1;
        check("t1_awready", 32'(s_axi_awready), 32'h1);
        check("t1_no_cmd_in_hs", 32'(sram_cmd_valid), 32'h0);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        #1 check("t1_no_w_no_cmd", 32'(sram_cmd_valid), 32'h0);
        w_send(16'hBEEF, 2'b11, ok);
        check("t1_w_hs", 32'(ok), 32'h1);
        check("t1_bvalid_next", 32'(s_axi_bvalid), 32'h1);
        wait_b(bb + 1);
        check("t1_ncmd", 32'(cmd_addr_q.size() - cb), 32'd1);
        check("t1_addr", 32'(cmd_addr_q[cb]), 32'h8);
        check("t1_we", 32'(cmd_we_q[cb]), 32'h1);
        check("t1_data", 32'(cmd_data_q[cb]), 32'hBEEF);
        check("t1_strb", 32'(cmd_strb_q[cb]), 32'h3);
        check("t1_nb", 32'(b_id_q.size() - bb), 32'd1);
        check("t1_bid", 32'(b_id_q[bb]), 32'h3);
        check("t1_bresp", 32'(b_resp_q[bb]), 32'h0);

        // Arbitration out of reset plus read burst
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cb = cmd_addr_q.size(); rb = r_data_q.size();
        s_axi_arvalid = 1'b1; s_axi_arid = 4'h9; s_axi_araddr = 20'h0; s_axi_arlen = 8'd3;
        s_axi_awvalid = 1'b1; s_axi_awid = 4'h5; s_axi_awaddr = 20'h00040; s_axi_awlen = 8'd1;
        #1;
        check("arb1_arready", 32'(s_axi_arready), 32'h1);
        check("arb1_awready", 32'(s_axi_awready), 32'h0);
        @(negedge clk);
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
        #1;
        check("t2_first_cmd_valid", 32'(sram_cmd_valid), 32'h1);
        check("t2_first_cmd_addr", 32'(sram_cmd_addr), 32'h0);
        wait_r(rb + 4, 40);
        check("t2_nr", 32'(r_data_q.size() - rb), 32'd4);
        check("t2_ncmd", 32'(cmd_addr_q.size() - cb), 32'd4);
        if (r_data_q.size() >= rb + 4 && cmd_addr_q.size() >= cb + 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t2_cmd_addr%0d", k), 32'(cmd_addr_q[cb+k]), 32'(k));
                check($sformatf("t2_cmd_we%0d", k), 32'(cmd_we_q[cb+k]), 32'h0);
                check($sformatf("t2_rdata%0d", k), 32'(r_data_q[rb+k]), 32'h1111 * (k + 1));
                check($sformatf("t2_rlast%0d", k), 32'(r_last_q[rb+k]), (k == 3) ? 32'h1 : 32'h0);
                check($sformatf("t2_rid%0d", k), 32'(r_id_q[rb+k]), 32'h9);
            end
        end

        // Second contest: read was served last, so write wins
        cb = cmd_addr_q.size(); bb = b_id_q.size();
        s_axi_arvalid = 1'b1; s_axi_arid = 4'h2; s_axi_araddr = 20'h00006; s_axi_arlen = 8'd0;
        s_axi_awvalid = 1'b1; s_axi_awid = 4'h5; s_axi_awaddr = 20'h00040; s_axi_awlen = 8'd1;
        #1;
        check("arb2_awready", 32'(s_axi_awready), 32'h1);
        check("arb2_arready", 32'(s_axi_arready), 32'h0);
        @(negedge clk);
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
        w_send(16'h5A01, 2'b11, ok);
        w_send(16'h5A02, 2'b01, ok);
        wait_b(bb + 1);
        check("t3_nb", 32'(b_id_q.size() - bb), 32'd1);
        check("t3_bid", 32'(b_id_q[bb]), 32'h5);
        check("t3_ncmd", 32'(cmd_addr_q.size() - cb), 32'd2);
        check("t3_addr0", 32'(cmd_addr_q[cb]), 32'h20);
        check("t3_addr1", 32'(cmd_addr_q[cb+1]), 32'h21);
        check("t3_data1", 32'(cmd_data_q[cb+1]), 32'h5A02);
        check("t3_strb1", 32'(cmd_strb_q[cb+1]), 32'h1);

        // Third contest: write was served last, so read wins
        rb = r_data_q.size();
        s_axi_arvalid = 1'b1; s_axi_awvalid = 1'b1;
        #1;
        check("arb3_arready", 32'(s_axi_arready), 32'h1);
        check("arb3_awready", 32'(s_axi_awready), 32'h0);
        @(negedge clk);
        s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
        wait_r(rb + 1, 20);
        check("t4_nr", 32'(r_data_q.size() - rb), 32'd1);
        check("t4_rdata", 32'(r_data_q[rb]), 32'h4444);
        check("t4_rlast", 32'(r_last_q[rb]), 32'h1);
        check("t4_rid", 32'(r_id_q[rb]), 32'h2);

        // Backpressure: toggling cmd ready, then rready held low mid-burst
        tog_en = 1'b1;
        cb = cmd_addr_q.size(); bb = b_id_q.size();
        aw_send(4'h1, 20'h00100, 8'd3, ok);
        check("t5_aw_hs", 32'(ok), 32'h1);
        w_send(16'hA001, 2'b11, ok);
        w_send(16'hA002, 2'b01, ok);
        w_send(16'hA003, 2'b10, ok);
        w_send(16'hA004, 2'b11, ok);
        wait_b(bb + 1);
        check("t5_nb", 32'(b_id_q.size() - bb), 32'd1);
        check("t5_ncmd", 32'(cmd_addr_q.size() - cb), 32'd4);
        if (cmd_addr_q.size() >= cb + 4) begin
            check("t5_addr3", 32'(cmd_addr_q[cb+3]), 32'h83);
            check("t5_data0", 32'(cmd_data_q[cb]), 32'hA001);
            check("t5_data2", 32'(cmd_data_q[cb+2]), 32'hA003);
            check("t5_strb2", 32'(cmd_strb_q[cb+2]), 32'h2);
        end
        cb = cmd_addr_q.size(); rb = r_data_q.size();
        ar_send(4'h7, 20'h00200, 8'd3, ok);
        check("t6_ar_hs", 32'(ok), 32'h1);
        wait_r(rb + 2, 40);
        s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t6_stall_rvalid", 32'(s_axi_rvalid), 32'h1);
        check("t6_stall_nr", 32'(r_data_q.size() - rb), 32'd2);
        s_axi_rready = 1'b1;
        wait_r(rb + 4, 40);
        check("t6_nr", 32'(r_data_q.size() - rb), 32'd4);
        check("t6_ncmd", 32'(cmd_addr_q.size() - cb), 32'd4);
        if (r_data_q.size() >= rb + 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t6_rdata%0d", k), 32'(r_data_q[rb+k]), 32'h1111 * (k + 1));
                check($sformatf("t6_rlast%0d", k), 32'(r_last_q[rb+k]), (k == 3) ? 32'h1 : 32'h0);
            end
        end
        tog_en = 1'b0;

        // Address wrap and 256-beat burst
        cb = cmd_addr_q.size(); rb = r_data_q.size();
        ar_send(4'hA, 20'hFFFFE, 8'hFF, ok);
        check("t7_first_cmd_addr", 32'(sram_cmd_addr), 32'h7FFFF);
        wait_r(rb + 256, 600);
        check("t7_nr", 32'(r_data_q.size() - rb), 32'd256);
        check("t7_ncmd", 32'(cmd_addr_q.size() - cb), 32'd256);
        if (r_data_q.size() >= rb + 256 && cmd_addr_q.size() >= cb + 256) begin
            nl = 0;
            for (int k = 0; k < 256; k++) nl += int'(r_last_q[rb+k]);
            check("t7_cmd_addr1", 32'(cmd_addr_q[cb+1]), 32'h0);
            check("t7_cmd_addr255", 32'(cmd_addr_q[cb+255]), 32'hFE);
            check("t7_rdata0", 32'(r_data_q[rb]), 32'h0000);
            check("t7_rdata1", 32'(r_data_q[rb+1]), 32'h1111);
            check("t7_nlast", 32'(nl), 32'd1);
            check("t7_last255", 32'(r_last_q[rb+255]), 32'h1);
            check("t7_rid255", 32'(r_id_q[rb+255]), 32'hA);
        end

        // Reset in the middle of a read, then a normal write
        rb = r_data_q.size();
        ar_send(4'h4, 20'h00020, 8'd3, ok);
        wait_r(rb + 2, 40);
        rst = 1'b1;
        @(negedge clk);
        #1 check("t8_outs_after_rst", 32'(outs_vec), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        #1 check("t8_idle_outs", 32'(outs_vec), 32'h0);
        check("t8_nr", 32'(r_data_q.size() - rb), 32'd2);
        cb = cmd_addr_q.size(); bb = b_id_q.size();
        aw_send(4'h6, 20'h00030, 8'd0, ok);
        check("t8_aw_hs", 32'(ok), 32'h1);
        w_send(16'h1234, 2'b11, ok);
        wait_b(bb + 1);
        check("t8_nb", 32'(b_id_q.size() - bb), 32'd1);
        check("t8_ncmd", 32'(cmd_addr_q.size() - cb), 32'd1);
        if (cmd_addr_q.size() >= cb + 1 && b_id_q.size() >= bb + 1) begin
            check("t8_addr", 32'(cmd_addr_q[cb]), 32'h18);
            check("t8_data", 32'(cmd_data_q[cb]), 32'h1234);
            check("t8_bid", 32'(b_id_q[bb]), 32'h6);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
